// File: rtl/add_round_key_stage.sv
// Registered AES-256 AddRoundKey stage: selects raw, column-mixed or shifted-only
// state by round, XORs in the round key and queues results in a 2-entry FIFO.
//
// Handshake: a beat transfers upstream when in_valid & in_ready, downstream when
// out_valid & out_ready. in_ready depends only on the registered fill count, so a
// full FIFO never accepts a beat even if the head pops in the same cycle.
module add_round_key_stage #(
  parameter int NR = 14,
  parameter int RW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_first,
  input  logic [127:0]  sr_data,
  input  logic [127:0]  mc_data,
  input  logic [127:0]  round_key,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_data,
  output logic [RW-1:0] out_round,
  output logic          out_last,
  output logic          err
);

  localparam logic [RW-1:0] NR_R = RW'(NR);

  logic [1:0]    count;
  logic [RW-1:0] rnd;

  // Head entry drives the outputs directly; the tail entry is the second slot.
  logic [127:0]  head_data;
  logic [RW-1:0] head_round;
  logic          head_last;
  logic [127:0]  tail_data;
  logic [RW-1:0] tail_round;
  logic          tail_last;

  logic          accept;
  logic          pop;
  logic          push;
  logic          beat_push;
  logic          beat_err;
  logic [127:0]  beat_data;
  logic [RW-1:0] beat_round;
  logic          beat_last;
  logic [RW-1:0] rnd_next;

  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign push      = accept & beat_push;

  assign out_data  = head_data;
  assign out_round = head_round;
  assign out_last  = head_last;

  always_comb begin
    beat_push  = 1'b1;
    beat_err   = 1'b0;
    beat_data  = sr_data ^ round_key;
    beat_round = '0;
    beat_last  = 1'b0;
    rnd_next   = rnd;
    if (in_first) begin
      // A first beat always restarts the block, even mid-block.
      rnd_next = RW'(1);
    end else if (rnd == '0) begin
      beat_push = 1'b0;
      beat_err  = 1'b1;
    end else if (rnd == NR_R) begin
      beat_round = NR_R;
      beat_last  = 1'b1;
      rnd_next   = '0;
    end else begin
      beat_data  = mc_data ^ round_key;
      beat_round = rnd;
      rnd_next   = rnd + RW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd <= '0;
      err <= 1'b0;
    end else if (accept) begin
      rnd <= rnd_next;
      if (beat_err) err <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= 2'd0;
      head_data  <= '0;
      head_round <= '0;
      head_last  <= 1'b0;
      tail_data  <= '0;
      tail_round <= '0;
      tail_last  <= 1'b0;
    end else begin
      case (count)
        2'd0: begin
          if (push) begin
            head_data  <= beat_data;
            head_round <= beat_round;
            head_last  <= beat_last;
            count      <= 2'd1;
          end
        end
        2'd1: begin
          if (push && pop) begin
            head_data  <= beat_data;
            head_round <= beat_round;
            head_last  <= beat_last;
          end else if (push) begin
            tail_data  <= beat_data;
            tail_round <= beat_round;
            tail_last  <= beat_last;
            count      <= 2'd2;
          end else if (pop) begin
            // Head registers keep their value so outputs hold while empty.
            count <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            head_data  <= tail_data;
            head_round <= tail_round;
            head_last  <= tail_last;
            count      <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/add_round_key_stage.md
Name: add_round_key_stage

Overview:
- Registered AddRoundKey stage for the AES-256 encryption datapath. It sits directly downstream of the column-mixing stage.
- Per beat it selects the round state:
  - raw input state for round 0;
  - column-mixed state for rounds 1..NR-1;
  - shifted-only state for final round NR, which has no column mixing.
- It XORs the selected state with the supplied round key and tracks the round number.
- Results go into a 2-entry output FIFO with valid/ready handshake, so the upstream round logic is decoupled from the consumer.

Parameters:
- NR, 14, number of AES rounds (14 for AES-256). The round counter covers 0..NR.
- RW, 4, width of the round-number fields. Must satisfy 2^RW > NR.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream beat valid.
- in_ready  output  1  stage can accept a beat this cycle.
- in_first  input  1  beat is round 0 (initial key addition); qualified by in_valid.
- sr_data  input  128  state before column mixing (raw state when in_first=1); byte 0 = [127:120].
- mc_data  input  128  column-mixed state for rounds 1..NR-1.
- round_key  input  128  round key for this beat.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  downstream accepts the head.
- out_data  output  128  head state after key addition.
- out_round  output  RW  round number of the head beat.
- out_last  output  1  head is round NR (ciphertext).
- err  output  1  sticky protocol-error flag.

Behaviour:
- Reset (async assert, sync release): FIFO empty, rnd=0, err=0, out_valid=0, out_data=0, out_round=0, out_last=0. Since the FIFO is empty, in_ready=1 after reset.
- Handshakes:
  - accept = in_valid & in_ready;
  - pop = out_valid & out_ready;
  - in_ready = (count<2), combinational from the registered count only, with no dependence on out_ready.
  - At count=2 a simultaneous pop does not enable a push in the same cycle.
- Beat computation on accept:
  - in_first=1: data = sr_data ^ round_key; tag round 0; rnd <= 1.
  - in_first=0, 1<=rnd<=NR-1: data = mc_data ^ round_key; tag rnd; rnd <= rnd+1.
  - in_first=0, rnd==NR: data = sr_data ^ round_key; tag NR with last=1; rnd <= 0.
  - in_first=0, rnd==0: protocol error. Beat is consumed and discarded (nothing pushed), err <= 1, rnd stays 0.
  - in_first=1 while rnd!=0: abort the current block and restart at round 0 as above. No error is raised, and entries already in the FIFO are kept.
- Latency: an accepted beat is visible at the FIFO head on the next edge if the FIFO was empty or the head popped. There is no combinational input-to-output path.
- FIFO:
  - 2 entries, each data 128 + round RW + last 1; order preserved.
  - Push and pop in the same cycle at count=1 leaves count=1, with the new beat at the head next cycle.
  - Pop at count=0 is impossible (out_valid=0). Push at count=2 is impossible (in_ready=0).
- Outputs are driven from the head entry. When empty, out_valid=0 and the data/round/last outputs hold their last values (0 after reset).
- err is cleared only by rst_n.
- Reset asserted mid-block or with a full FIFO clears all state immediately. The next block must start with in_first=1.
- mc_data is ignored for round 0 and round NR; sr_data is ignored for rounds 1..NR-1.

Test Plan:
- Round 0 (FIPS-197 C.3): in_first=1, sr_data=00112233445566778899aabbccddeeff, round_key=000102030405060708090a0b0c0d0e0f. Expect out_data=00102030405060708090a0b0c0d0e0f0, out_round=0, out_last=0, out_valid high 1 cycle after accept.
- Full block, 15 beats, out_ready=1: beat k (1..13) sends mc_data=k-replicated bytes, sr_data=all-FF, key=0. Expect output rounds 0..14 in order; rounds 1..13 equal mc_data; round 14 equals FF..FF with out_last=1; rnd returns to 0.
- Backpressure, out_ready=0: after 2 accepts in_ready=0 and a third beat is held upstream. Raising out_ready pops round 0, then round 1; in_ready reasserts the cycle after count drops below 2.
- Error: after reset, send in_valid=1 with in_first=0. Expect no output, err=1 and sticky. A following in_first=1 beat is processed normally as round 0.
- Restart: in_first=1 injected at rnd=5. Expect out_round sequence …,4,0,1,… with err=0.
- Async reset asserted with 2 entries queued: out_valid and err drop to 0 immediately and in_ready=1 after release.
